// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the lab CPU.
// Imported by the register file and reusable by decode, ALU and writeback.
package regfile_pkg;

   localparam int WIDTH  = 64;
   localparam int NREGS  = 32;
   localparam int ADDR_W = $clog2(NREGS);

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [WIDTH-1:0]  reg_word_t;

   // X31 reads as zero (XZR); writes to it are discarded.
   localparam reg_addr_t ZERO_REG = reg_addr_t'(NREGS - 1);

endpackage

// File: rtl/regfile_read_port.sv
// One registered read path: storage mux, zero-register force,
// same-edge write bypass and an output register that holds while rd_en is low.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      rd_en,
   input  reg_addr_t rd_addr,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  reg_word_t wr_data,
   input  reg_word_t regs [NREGS],
   output reg_word_t rd_data
);

   reg_word_t next_data;

   // NOTE: assign a default first so every path through always_comb drives next_data; no latch.
   always_comb begin
      next_data = regs[rd_addr];
      if (rd_addr == ZERO_REG) begin
         next_data = '0;
      end else if (wr_en && (wr_addr == rd_addr)) begin
         next_data = wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= next_data;
      end
   end

endmodule

// File: rtl/regfile_read_2r1w.sv
// 32 x 64-bit register file: one write port with XZR suppression and two
// registered read ports with write-through bypass.
module regfile_read_2r1w
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  reg_word_t wr_data,
   input  reg_addr_t rd_addr1,
   input  reg_addr_t rd_addr2,
   input  logic      rd_en,
   output reg_word_t rd_data1,
   output reg_word_t rd_data2
);

   reg_word_t regs [NREGS];

   // NOTE: the storage array is reset explicitly because software relies on every register reading 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != ZERO_REG)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   regfile_read_port u_port1 (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (rd_addr1),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (regs),
      .rd_data (rd_data1)
   );

   regfile_read_port u_port2 (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (rd_addr2),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (regs),
      .rd_data (rd_data2)
   );

endmodule
